// File: rtl/postbox_link_ctrl_if.sv
// Bus bundle between the POST link controller, its two transmit requesters,
// the debug engine's tx/rx buffers and the downstream receive stream.
interface postbox_link_ctrl_if;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] txin;
    logic       txstart;
    logic       txempty;
    logic [7:0] rxout;
    logic       rxfull;
    logic       rxreset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_owner;
    logic       tx_stall;

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid,
               txempty, rxout, rxfull, rx_ready,
        output req0_ready, req1_ready, txin, txstart, rxreset,
               rx_data, rx_valid, rx_owner, tx_stall
    );

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid,
               txempty, rxout, rxfull, rx_ready,
        input  req0_ready, req1_ready, txin, txstart, rxreset,
               rx_data, rx_valid, rx_owner, tx_stall
    );
endinterface

// File: rtl/postbox_link_ctrl.sv
// Round-robin tx arbiter with txstart/txempty sequencing, rx drain into a
// valid/ready stream with rxreset strobe, and a tx stall watchdog.
module postbox_link_ctrl #(
    parameter int unsigned STALL_MAX   = 4800000,
    parameter int unsigned STALL_WIDTH = 23
) (
    input  logic                refclk,
    input  logic                reset_n,
    postbox_link_ctrl_if.slave  bus
);

    localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(STALL_MAX);

    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_CLEAR} rx_state_e;

    tx_state_e              tx_state_q;
    rx_state_e              rx_state_q;
    logic                   prio_q;
    logic [7:0]             txin_q;
    logic                   txstart_q;
    logic                   rxreset_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   rx_owner_q;
    logic                   tx_stall_q;
    logic [STALL_WIDTH-1:0] stall_cnt_q;
    logic [STALL_WIDTH-1:0] stall_cnt_d;

    logic grant_c;
    logic win_c;

    // Arbitration: one grant per idle cycle, ties go to prio_q.
    always_comb begin
        grant_c = 1'b0;
        win_c   = prio_q;
        if (reset_n && (tx_state_q == T_IDLE) && bus.txempty) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_c = 1'b1;
                win_c   = prio_q;
            end else if (bus.req0_valid) begin
                grant_c = 1'b1;
                win_c   = 1'b0;
            end else if (bus.req1_valid) begin
                grant_c = 1'b1;
                win_c   = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_c && !win_c;
    assign bus.req1_ready = grant_c &&  win_c;

    // Watchdog counts cycles the engine buffer stays full, excluding the issue cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.txempty || (tx_state_q == T_ISSUE)) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_LIMIT) begin
            stall_cnt_d = stall_cnt_q + STALL_WIDTH'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            tx_state_q  <= T_IDLE;
            rx_state_q  <= R_IDLE;
            prio_q      <= 1'b0;
            txin_q      <= 8'h00;
            txstart_q   <= 1'b0;
            rxreset_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_owner_q  <= 1'b0;
            tx_stall_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            tx_stall_q  <= (stall_cnt_d == STALL_LIMIT);
            txstart_q   <= 1'b0;
            rxreset_q   <= 1'b0;

            case (tx_state_q)
                T_IDLE: begin
                    if (grant_c) begin
                        txin_q     <= win_c ? bus.req1_data : bus.req0_data;
                        rx_owner_q <= win_c;
                        prio_q     <= ~win_c;
                        txstart_q  <= 1'b1;
                        tx_state_q <= T_ISSUE;
                    end
                end
                T_ISSUE: tx_state_q <= T_WAIT;
                // txempty lags the strobe by a cycle; only its fall ends the wait
                T_WAIT: begin
                    if (!bus.txempty) begin
                        tx_state_q <= T_IDLE;
                    end
                end
                default: tx_state_q <= T_IDLE;
            endcase

            case (rx_state_q)
                R_IDLE: begin
                    if (bus.rxfull) begin
                        rx_data_q  <= bus.rxout;
                        rx_valid_q <= 1'b1;
                        rx_state_q <= R_HOLD;
                    end
                end
                R_HOLD: begin
                    if (rx_valid_q && bus.rx_ready) begin
                        rx_valid_q <= 1'b0;
                        rxreset_q  <= 1'b1;
                        rx_state_q <= R_CLEAR;
                    end
                end
                // Wait out the engine's late rxfull clear to avoid a double capture
                R_CLEAR: begin
                    if (!bus.rxfull) begin
                        rx_state_q <= R_IDLE;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    assign bus.txin     = txin_q;
    assign bus.txstart  = txstart_q;
    assign bus.rxreset  = rxreset_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_owner = rx_owner_q;
    assign bus.tx_stall = tx_stall_q;

endmodule

// File: tb/tb_postbox_link_ctrl.sv
// Directed cycle-by-cycle vectors for postbox_link_ctrl with a short stall limit.
module tb_postbox_link_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int unsigned NV = 28;

    typedef struct {
        logic       rst_n;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       te;
        logic       rf;
        logic [7:0] ro;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic [7:0] e_txin;
        logic       e_ts;
        logic       e_rxr;
        logic [7:0] e_rxd;
        logic       e_rxv;
        logic       e_own;
        logic       e_st;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    vec_t tbl [NV];

    postbox_link_ctrl_if bus();

    postbox_link_ctrl #(
        .STALL_MAX  (10),
        .STALL_WIDTH(4)
    ) dut (
        .refclk (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst_i, input logic v0, input logic [7:0] d0,
        input logic v1, input logic [7:0] d1, input logic te,
        input logic rf, input logic [7:0] ro, input logic rr,
        input logic r0, input logic r1, input logic [7:0] txin,
        input logic ts, input logic rxr, input logic [7:0] rxd,
        input logic rxv, input logic own, input logic st);
        vec_t v;
        v.rst_n = rst_i; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.te = te; v.rf = rf; v.ro = ro; v.rr = rr;
        v.e_r0 = r0; v.e_r1 = r1; v.e_txin = txin; v.e_ts = ts;
        v.e_rxr = rxr; v.e_rxd = rxd; v.e_rxv = rxv; v.e_own = own; v.e_st = st;
        return v;
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        else
            n_pass++;
    endtask

    // Drive on the falling edge, check readies before the rising edge and registers after it.
    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        rst_n          = v.rst_n;
        bus.req0_valid = v.v0;
        bus.req0_data  = v.d0;
        bus.req1_valid = v.v1;
        bus.req1_data  = v.d1;
        bus.txempty    = v.te;
        bus.rxfull     = v.rf;
        bus.rxout      = v.ro;
        bus.rx_ready   = v.rr;
        #1;
        chk(tag, "req0_ready", 8'(bus.req0_ready), 8'(v.e_r0));
        chk(tag, "req1_ready", 8'(bus.req1_ready), 8'(v.e_r1));
        @(posedge clk);
        #1;
        chk(tag, "txin",     bus.txin,             v.e_txin);
        chk(tag, "txstart",  8'(bus.txstart),      8'(v.e_ts));
        chk(tag, "rxreset",  8'(bus.rxreset),      8'(v.e_rxr));
        chk(tag, "rx_data",  bus.rx_data,          v.e_rxd);
        chk(tag, "rx_valid", 8'(bus.rx_valid),     8'(v.e_rxv));
        chk(tag, "rx_owner", 8'(bus.rx_owner),     8'(v.e_own));
        chk(tag, "tx_stall", 8'(bus.tx_stall),     8'(v.e_st));
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
        bus.txempty = 1'b1; bus.rxfull = 1'b0; bus.rxout = 8'h00; bus.rx_ready = 1'b0;

        //                rst v0 d0     v1 d1     te rf ro     rr   r0 r1 txin   ts rxr rxd    rxv own st
        tbl[0]  = mk(L, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h00, L, L, 8'h00, L, L, L);
        tbl[1]  = mk(H, H, 8'hA5, L, 8'h00, H, L, 8'h00, L,  H, L, 8'hA5, H, L, 8'h00, L, L, L);
        tbl[2]  = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'hA5, L, L, 8'h00, L, L, L);
        tbl[3]  = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'hA5, L, L, 8'h00, L, L, L);
        tbl[4]  = mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'hA5, L, L, 8'h00, L, L, L);
        tbl[5]  = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'hA5, L, L, 8'h00, L, L, L);
        // reset with both requesters pending, then contention from prio 0
        tbl[6]  = mk(L, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  L, L, 8'h00, L, L, 8'h00, L, L, L);
        tbl[7]  = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  H, L, 8'h11, H, L, 8'h00, L, L, L);
        tbl[8]  = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[9]  = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[10] = mk(H, H, 8'h11, H, 8'h22, L, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[11] = mk(H, H, 8'h11, H, 8'h22, L, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[12] = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  L, H, 8'h22, H, L, 8'h00, L, H, L);
        tbl[13] = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  L, L, 8'h22, L, L, 8'h00, L, H, L);
        tbl[14] = mk(H, H, 8'h11, H, 8'h22, L, L, 8'h00, L,  L, L, 8'h22, L, L, 8'h00, L, H, L);
        tbl[15] = mk(H, H, 8'h11, H, 8'h22, H, L, 8'h00, L,  H, L, 8'h11, H, L, 8'h00, L, L, L);
        tbl[16] = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[17] = mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        tbl[18] = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h00, L, L, L);
        // receive with a slow consumer and a lagging rxfull
        tbl[19] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, L,  L, L, 8'h11, L, L, 8'h3C, H, L, L);
        tbl[20] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, L,  L, L, 8'h11, L, L, 8'h3C, H, L, L);
        tbl[21] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, L,  L, L, 8'h11, L, L, 8'h3C, H, L, L);
        tbl[22] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, L,  L, L, 8'h11, L, L, 8'h3C, H, L, L);
        tbl[23] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, L,  L, L, 8'h11, L, L, 8'h3C, H, L, L);
        tbl[24] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, H,  L, L, 8'h11, L, H, 8'h3C, L, L, L);
        tbl[25] = mk(H, L, 8'h00, L, 8'h00, H, H, 8'h3C, H,  L, L, 8'h11, L, L, 8'h3C, L, L, L);
        tbl[26] = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, H,  L, L, 8'h11, L, L, 8'h3C, L, L, L);
        tbl[27] = mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h11, L, L, 8'h3C, L, L, L);

        for (int i = 0; i < int'(NV); i++)
            run(tbl[i], $sformatf("V%0d", i));

        // Stall: txempty held low from the issue cycle, limit 10
        run(mk(H, H, 8'h5A, L, 8'h00, H, L, 8'h00, L,  H, L, 8'h5A, H, L, 8'h3C, L, L, L), "S_issue");
        run(mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h5A, L, L, 8'h3C, L, L, L), "S_tissue");
        for (int i = 1; i <= 9; i++)
            run(mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h5A, L, L, 8'h3C, L, L, L),
                $sformatf("S_cnt%0d", i));
        run(mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h5A, L, L, 8'h3C, L, L, H), "S_cnt10");
        run(mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h5A, L, L, 8'h3C, L, L, H), "S_sat");
        run(mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h5A, L, L, 8'h3C, L, L, L), "S_clear");

        // Concurrent grant to req1 and rx capture
        run(mk(H, L, 8'h00, H, 8'h77, H, H, 8'hC3, L,  L, H, 8'h77, H, L, 8'hC3, H, H, L), "C1");
        run(mk(H, L, 8'h00, L, 8'h00, H, H, 8'hC3, H,  L, L, 8'h77, L, H, 8'hC3, L, H, L), "C2");
        run(mk(H, L, 8'h00, L, 8'h00, L, L, 8'h00, L,  L, L, 8'h77, L, L, 8'hC3, L, H, L), "C3");
        run(mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h77, L, L, 8'hC3, L, H, L), "C4");

        // Reset during T_ISSUE and R_HOLD; rxfull still high re-captures the byte
        run(mk(H, H, 8'hE7, L, 8'h00, H, H, 8'h9D, L,  H, L, 8'hE7, H, L, 8'h9D, H, L, L), "R1");
        run(mk(L, L, 8'h00, L, 8'h00, H, H, 8'h9D, L,  L, L, 8'h00, L, L, 8'h00, L, L, L), "R2");
        run(mk(H, L, 8'h00, L, 8'h00, H, H, 8'h9D, L,  L, L, 8'h00, L, L, 8'h9D, H, L, L), "R3");
        run(mk(H, L, 8'h00, L, 8'h00, H, H, 8'h9D, H,  L, L, 8'h00, L, H, 8'h9D, L, L, L), "R4");
        run(mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h00, L, L, 8'h9D, L, L, L), "R5");
        run(mk(H, H, 8'h01, H, 8'h02, H, L, 8'h00, L,  H, L, 8'h01, H, L, 8'h9D, L, L, L), "R6");
        run(mk(H, L, 8'h00, L, 8'h00, H, L, 8'h00, L,  L, L, 8'h01, L, L, 8'h9D, L, L, L), "R7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/postbox_link_ctrl.md
Name: postbox_link_ctrl

Overview:
Host-side controller that sits between the POST debug interface engine and the host-facing byte streams. It arbitrates two transmit requesters (req0 = host link, req1 = scripted responder) onto the engine's single txin/txstart path using round-robin. It sequences the txstart/txempty handshake and drains received bytes into a valid/ready stream, generating the rxreset strobe. It also flags a transmit stall when the target stops polling for input.

Parameters:
STALL_MAX, 4800000, refclk cycles that txempty may stay low after an issue before tx_stall asserts (100 ms at 48 MHz)
STALL_WIDTH, 23, bit width of stall counter; must hold STALL_MAX

Ports:
refclk  in  1  48 MHz reference clock; all logic on its rising edge
reset_n  in  1  synchronous active-low reset
req0_data  in  8  byte from requester 0
req0_valid  in  1  requester 0 has a byte
req0_ready  out  1  requester 0 byte accepted this cycle (combinational)
req1_data  in  8  byte from requester 1
req1_valid  in  1  requester 1 has a byte
req1_ready  out  1  requester 1 byte accepted this cycle (combinational)
txin  out  8  byte to engine (registered)
txstart  out  1  one-cycle strobe to engine (registered)
txempty  in  1  engine can accept a byte
rxout  in  8  byte received by engine
rxfull  in  1  rxout valid
rxreset  out  1  one-cycle strobe releasing engine rx buffer (registered)
rx_data  out  8  captured received byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  downstream accepts rx_data
rx_owner  out  1  index of requester whose byte was most recently accepted
tx_stall  out  1  target not draining tx byte

Behaviour:
- Reset (reset_n=0 at edge): txin=0, txstart=0, rxreset=0, rx_data=0, rx_valid=0, rx_owner=0, tx_stall=0, stall counter=0, prio=0, tx FSM=T_IDLE, rx FSM=R_IDLE. reqN_ready=0 during reset.
- TX FSM:
  - T_IDLE: if txempty=1 and any reqN_valid, pick a winner.
    - Both valid: winner = prio.
    - One valid: that requester wins.
    - Assert winner's ready combinationally this cycle (never both). Register txin<=data, rx_owner<=winner, prio<=~winner, then go to T_ISSUE.
  - T_ISSUE: txstart=1 for exactly this cycle; clear stall counter; go to T_WAIT.
  - T_WAIT: return to T_IDLE when txempty=0. txempty stays high for one cycle after the strobe because the engine registers it; this is not a return.
- Throughput: at most one byte per 3 cycles plus engine drain time. No second txstart while the engine buffer is full.
- Stall counter:
  - Increments each cycle txempty=0 outside T_ISSUE, saturating at STALL_MAX.
  - tx_stall=1 while counter==STALL_MAX.
  - Counter and tx_stall clear on the cycle txempty=1 or on reset.
  - tx_stall does not block arbitration.
- RX FSM:
  - R_IDLE: if rxfull=1, capture rx_data<=rxout, rx_valid<=1, go to R_HOLD.
  - R_HOLD: on rx_valid&rx_ready, rx_valid<=0, rxreset<=1 (one cycle), go to R_CLEAR.
  - R_CLEAR: rxreset=0; wait until rxfull=0, then go to R_IDLE. This prevents double capture while the engine clears rxfull one cycle late.
- rx_data holds its value after rx_valid falls. rx_valid is never deasserted without a handshake.
- TX and RX FSMs are independent. An accept, a txstart, a capture and an rxreset may all occur in the same cycle.
- Reset mid-operation:
  - A pending txstart is cancelled; a byte already accepted by the engine is not recalled.
  - If rxfull is still high after reset, the byte is re-captured in R_IDLE. This duplicate is acceptable and expected.
- Only one request is considered per T_IDLE cycle. The loser keeps valid and wins next time (round-robin fairness: no requester waits more than one grant).

Test Plan:
- Single byte: req0 sends 0xA5, txempty=1 → req0_ready 1 cycle; txin=0xA5; txstart pulse 1 cycle later; rx_owner=0.
- Contention: both valid continuously (0x11/0x22), prio=0 → grants alternate 0,1,0,1. txstart pulses only after txempty has gone low then high, and never while txempty=0.
- Receive: rxfull=1, rxout=0x3C, rx_ready=0 for 5 cycles → rx_valid held with rx_data=0x3C, no rxreset. rx_ready=1 → one rxreset pulse. No recapture while rxfull lags one cycle.
- Stall: with STALL_MAX=10, hold txempty=0 after a txstart → tx_stall rises 10 cycles after T_WAIT entry. It clears the cycle txempty=1.
- Concurrent: rxfull rises on the same cycle req1_valid wins → both txstart and rx_valid occur with no interference. rx_owner=1.
- Reset mid-transfer: reset_n=0 during T_ISSUE and R_HOLD → txstart stays 0; all outputs zero next cycle. With rxfull still 1, rx_valid reasserts with the same byte after release.
